// File: rtl/g3f_pkg.sv
// Shared types and defaults for the g3f period meter.
package g3f_pkg;

  localparam int SAMPLE_W          = 6;
  localparam int G3F_CNT_W_DEF     = 8;
  localparam int G3F_STALL_MAX_DEF = 4;
  localparam int RUN_W             = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEASURE,
    ST_DONE,
    ST_STALL
  } g3f_pm_state_t;

endpackage

// File: rtl/g3f_stall_det.sv
// Repeat tracker: remembers the previous enabled sample and how many times in a row it has been seen.
module g3f_stall_det
  import g3f_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [RUN_W-1:0]    run,
  output logic                hit
);

  logic [SAMPLE_W-1:0] prev_q, prev_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic                same;

  always_comb begin
    same   = (sample == prev_q);
    prev_d = prev_q;
    run_d  = run_q;
    // clr loads the first sample of a run; en advances the run on a non-terminal sample
    if (clr) begin
      prev_d = sample;
      run_d  = RUN_W'(1);
    end else if (en) begin
      prev_d = sample;
      run_d  = same ? run_q + RUN_W'(1) : RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      run_q  <= '0;
    end else begin
      prev_q <= prev_d;
      run_q  <= run_d;
    end
  end

  assign run = run_q;
  assign hit = same;

endmodule

// File: rtl/g3f_period_meter.sv
// Period and lock-up meter for the g3f sequence generator.
// Optional `stable` output is built when G3F_PERIOD_STABLE_EN is defined.
//
// state      | meaning
// IDLE       | no measurement yet since reset
// ARM        | waiting for the first enabled sample to capture as reference
// MEASURE    | counting enabled samples until the reference recurs
// DONE       | result available (period or overflow)
// STALL      | generator locked up on a non-reference value
module g3f_period_meter
  import g3f_pkg::*;
#(
  parameter int CNT_W     = G3F_CNT_W_DEF,
  parameter int STALL_MAX = G3F_STALL_MAX_DEF
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             se,
  input  logic [2:0]       q,
  input  logic [2:0]       p,
  input  logic             start,
  output logic             busy,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             overflow,
  output logic             stall
`ifdef G3F_PERIOD_STABLE_EN
  ,output logic            stable
`endif
);

  g3f_pm_state_t       state_q, state_d;
  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]    period_q, period_d;
  logic                pv_q, pv_d;
  logic                ovf_q, ovf_d;
  logic                stall_q, stall_d;
  logic                sd_clr, sd_en, rep_hit;
  logic [RUN_W-1:0]    run;
  logic [RUN_W:0]      run_nx;
`ifdef G3F_PERIOD_STABLE_EN
  logic [CNT_W-1:0]    last_q, last_d;
  logic                stable_q, stable_d;
`endif

  assign sample = {q, p};

  g3f_stall_det u_stall_det (
    .clk    (clk),
    .rst    (rst),
    .clr    (sd_clr),
    .en     (sd_en),
    .sample (sample),
    .run    (run),
    .hit    (rep_hit)
  );

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    ovf_d    = ovf_q;
    stall_d  = stall_q;
    sd_clr   = 1'b0;
    sd_en    = 1'b0;
    cnt_inc  = cnt_q + CNT_W'(1);
    run_nx   = {1'b0, run} + (RUN_W+1)'(1);
`ifdef G3F_PERIOD_STABLE_EN
    last_d   = last_q;
    stable_d = stable_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_STALL: begin
        if (start) begin
          state_d = ST_ARM;
          ovf_d   = 1'b0;
          stall_d = 1'b0;
        end
      end
      ST_ARM: begin
        if (se) begin
          ref_d   = sample;
          cnt_d   = '0;
          sd_clr  = 1'b1;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (se) begin
          // recurrence wins over overflow and stall, so a stuck-on-ref generator reads as period 1
          if (sample == ref_q) begin
            period_d = cnt_inc;
            pv_d     = 1'b1;
            state_d  = ST_DONE;
`ifdef G3F_PERIOD_STABLE_EN
            stable_d = (cnt_inc == last_q);
            last_d   = cnt_inc;
`endif
          end else if (cnt_inc == '1) begin
            period_d = '1;
            ovf_d    = 1'b1;
            pv_d     = 1'b1;
            state_d  = ST_DONE;
          end else if (rep_hit && (run_nx == (RUN_W+1)'(STALL_MAX))) begin
            stall_d  = 1'b1;
            state_d  = ST_STALL;
`ifdef G3F_PERIOD_STABLE_EN
            stable_d = 1'b0;
            last_d   = '0;
`endif
          end else begin
            cnt_d = cnt_inc;
            sd_en = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ref_q    <= '0;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      stall_q  <= 1'b0;
`ifdef G3F_PERIOD_STABLE_EN
      last_q   <= '0;
      stable_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      ovf_q    <= ovf_d;
      stall_q  <= stall_d;
`ifdef G3F_PERIOD_STABLE_EN
      last_q   <= last_d;
      stable_q <= stable_d;
`endif
    end
  end

  assign busy         = (state_q == ST_ARM) || (state_q == ST_MEASURE);
  assign period       = period_q;
  assign period_valid = pv_q;
  assign overflow     = ovf_q;
  assign stall        = stall_q;
`ifdef G3F_PERIOD_STABLE_EN
  assign stable       = stable_q;
`endif

endmodule

// File: tb/tb_g3f_period_meter.sv
// Directed bench for g3f_period_meter; stable checks are built when G3F_PERIOD_STABLE_EN is defined.
module tb_g3f_period_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       se = 1'b0;
  logic [2:0] q = '0;
  logic [2:0] p = '0;
  logic       start = 1'b0;
  logic       busy;
  logic [7:0] period;
  logic       period_valid;
  logic       overflow;
  logic       stall;
`ifdef G3F_PERIOD_STABLE_EN
  logic       stable;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  g3f_period_meter dut (
    .clk          (clk),
    .rst          (rst),
    .se           (se),
    .q            (q),
    .p            (p),
    .start        (start),
    .busy         (busy),
    .period       (period),
    .period_valid (period_valid),
    .overflow     (overflow),
    .stall        (stall)
`ifdef G3F_PERIOD_STABLE_EN
    ,.stable      (stable)
`endif
  );

  // outputs packed as {busy, period_valid, overflow, stall, period}
  typedef struct {
    logic        se;
    logic        st;
    logic [5:0]  s;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[11];
  logic [5:0] seq8[8] = '{6'h05, 6'h12, 6'h27, 6'h30, 6'h0B, 6'h1C, 6'h21, 6'h3E};

  function automatic logic [11:0] ob(input logic b, input logic v, input logic o,
                                     input logic s, input logic [7:0] per);
    return {b, v, o, s, per};
  endfunction

  function automatic logic [11:0] outs();
    return {busy, period_valid, overflow, stall, period};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic se_i, input logic st_i, input logic [5:0] s_i);
    se    = se_i;
    start = st_i;
    q     = s_i[5:3];
    p     = s_i[2:0];
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // start, then n+1 enabled samples base..base+n-1, base; expects one valid pulse with period n
  task automatic run_period(input string nm, input int n, input logic [5:0] base);
    drive(1'b0, 1'b1, 6'h00);
    for (int i = 0; i <= n; i++) begin
      drive(1'b1, 1'b0, base + 6'(i % n));
      if (i < n && period_valid) chk({nm, "_early_valid"}, 32'(period_valid), 32'd0);
    end
    chk({nm, "_result"}, 32'(outs()), 32'(ob(1'b0, 1'b1, 1'b0, 1'b0, 8'(n))));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic early;

    // 8-step cycle; start with se=1 must only arm; start while busy is ignored
    tbl[0] = '{1'b1, 1'b1, seq8[3], ob(1'b1, 1'b0, 1'b0, 1'b0, 8'd0)};
    tbl[1] = '{1'b1, 1'b0, seq8[0], ob(1'b1, 1'b0, 1'b0, 1'b0, 8'd0)};
    for (int i = 1; i < 8; i++)
      tbl[i+1] = '{1'b1, (i == 3), seq8[i], ob(1'b1, 1'b0, 1'b0, 1'b0, 8'd0)};
    tbl[9]  = '{1'b1, 1'b0, seq8[0], ob(1'b0, 1'b1, 1'b0, 1'b0, 8'd8)};
    tbl[10] = '{1'b1, 1'b0, seq8[1], ob(1'b0, 1'b0, 1'b0, 1'b0, 8'd8)};

    drive(1'b0, 1'b0, 6'h00);
    drive(1'b0, 1'b0, 6'h00);
    rst = 1'b0;
    drive(1'b0, 1'b0, 6'h00);
    chk("reset_state", 32'(outs()), 32'd0);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].se, tbl[i].st, tbl[i].s);
      chk($sformatf("tbl_%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // se toggling; disabled cycles present the reference value and must be ignored
    drive(1'b0, 1'b1, 6'h00);
    for (int i = 0; i <= 8; i++) begin
      drive(1'b0, 1'b0, seq8[0]);
      drive(1'b1, 1'b0, seq8[i % 8]);
      chk($sformatf("toggle_%0d", i), 32'(outs()),
          32'((i < 8) ? ob(1'b1, 1'b0, 1'b0, 1'b0, 8'd8) : ob(1'b0, 1'b1, 1'b0, 1'b0, 8'd8)));
    end

    // overflow: reference 63 never recurs
    drive(1'b0, 1'b1, 6'h00);
    drive(1'b1, 1'b0, 6'h3F);
    early = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      drive(1'b1, 1'b0, 6'((k - 1) % 63));
      if (k < 255 && (period_valid || overflow || !busy)) early = 1'b1;
      if (k == 255) chk("ovf_result", 32'(outs()), 32'(ob(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF)));
    end
    chk("ovf_early", 32'(early), 32'd0);
    chk("ovf_hold", 32'(outs()), 32'(ob(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF)));

    // stall on the 4th identical non-reference sample
    drive(1'b0, 1'b1, 6'h00);
    chk("stall_start", 32'(outs()), 32'(ob(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF)));
    drive(1'b1, 1'b0, 6'h01);
    drive(1'b1, 1'b0, 6'h02);
    drive(1'b1, 1'b0, 6'h03);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 6'h09);
    chk("stall_3rd", 32'(outs()), 32'(ob(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF)));
    drive(1'b1, 1'b0, 6'h09);
    chk("stall_4th", 32'(outs()), 32'(ob(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF)));
    drive(1'b1, 1'b0, 6'h09);
    chk("stall_hold", 32'(outs()), 32'(ob(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF)));
    drive(1'b0, 1'b1, 6'h00);
    chk("stall_clear", 32'(outs()), 32'(ob(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF)));

    // reset mid-measurement aborts with no result
    drive(1'b1, 1'b0, 6'h0A);
    drive(1'b1, 1'b0, 6'h0B);
    drive(1'b1, 1'b0, 6'h0C);
    rst = 1'b1;
    drive(1'b1, 1'b0, 6'h0A);
    rst = 1'b0;
    chk("abort_reset", 32'(outs()), 32'd0);
    early = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'h0A + 6'(i));
      if (outs() != 12'd0) early = 1'b1;
    end
    chk("abort_quiet", 32'(early), 32'd0);

    run_period("p5", 5, 6'd20);
    drive(1'b1, 1'b0, 6'd21);
    chk("p5_pulse_end", 32'(period_valid), 32'd0);
    run_period("p1", 1, 6'd40);

    run_period("p6a", 6, 6'd30);
`ifdef G3F_PERIOD_STABLE_EN
    chk("stable_p6a", 32'(stable), 32'd0);
`endif
    run_period("p6b", 6, 6'd50);
`ifdef G3F_PERIOD_STABLE_EN
    chk("stable_p6b", 32'(stable), 32'd1);
`endif
    run_period("p7", 7, 6'd10);
`ifdef G3F_PERIOD_STABLE_EN
    chk("stable_p7", 32'(stable), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
